e_muldiv_unit: RTL

- Parametrised successor to the E-stage HI/LO multiply/divide unit of the MIPS pipeline. Lives in the E stage.
- Executes mult/multu/div/divu and the accumulate ops madd/maddu/msub/msubu with configurable iteration latencies.
- Serves mfhi/mflo/mthi/mtlo and drives a busy indication to the stall logic.
- Supports flushing an in-flight operation on exception/branch cancel without corrupting HI/LO.

---
 rtl/e_muldiv_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/e_muldiv_unit.sv
// E-stage HI/LO multiply/divide unit: mult/div/accumulate ops with fixed, parameterised
// latency, mfhi/mflo/mthi/mtlo access, flushable in-flight operation.
//
// state  | meaning
// S_IDLE | no operation in flight; mthi/mtlo and start ops accepted
// S_BUSY | operation latched, counter running down to the commit edge
module e_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Op,
  input  logic             Flush,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic             IsBusy,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 start_op;
  logic                 div_op;

  logic [2*WIDTH-1:0]   prod_s, prod_u, res;
  logic                 div_signed;
  logic [WIDTH-1:0]     num, den, den_safe, quo_raw, rem_raw, quo, rem;

  always_comb begin
    start_op = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_DIV) || (Op == OP_DIVU) ||
               (Op == OP_MADD) || (Op == OP_MADDU) || (Op == OP_MSUB) || (Op == OP_MSUBU);
    div_op   = (Op == OP_DIV) || (Op == OP_DIVU);
  end

  // Result is combinational on the latched operands; only the commit edge is visible.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide runs on magnitudes; most-negative / -1 falls out as most-negative, rem 0.
    div_signed = (op_q == OP_DIV);
    num        = (div_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    den        = (div_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    den_safe   = (den == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : den;
    quo_raw    = num / den_safe;
    rem_raw    = num % den_safe;
    quo        = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~quo_raw + 1'b1) : quo_raw;
    rem        = (div_signed && a_q[WIDTH-1]) ? (~rem_raw + 1'b1) : rem_raw;

    res = '0;
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_MADD:  res = acc_q + prod_s;
      OP_MADDU: res = acc_q + prod_u;
      OP_MSUB:  res = acc_q - prod_s;
      OP_MSUBU: res = acc_q - prod_u;
      OP_DIV, OP_DIVU: res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          if (start_op) begin
            state_d = S_BUSY;
            cnt_d   = div_op ? DIV_N : MULT_N;
            op_d    = Op;
            a_d     = D1;
            b_d     = D2;
            acc_d   = {hi_q, lo_q};
          end else if (Op == OP_MTHI) begin
            hi_d = D1;
          end else if (Op == OP_MTLO) begin
            lo_d = D1;
          end
        end
      end
      S_BUSY: begin
        if (Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          {hi_d, lo_d}  = res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    IsBusy = (start_op && !Flush) || (state_q == S_BUSY);
    Out    = '0;
    if (Op == OP_MFHI)      Out = hi_q;
    else if (Op == OP_MFLO) Out = lo_q;
    Hi = hi_q;
    Lo = lo_q;
  end

endmodule
